// File: rtl/seq_mult_ctrl_pkg.sv
//-----------------------------------------------------------------------------
// seq_mult_pkg
//
// Shared definitions for the shift-add sequential multiplier controller:
//   - state_t       : 2-bit controller state encoding (IDLE/LOAD/ITER/DONE)
//   - MY_WIDTH_DFLT : default multiplier width (matches the legacy ROM)
//   - CTL_*         : bit positions inside the internal 7-bit control vector
//   - ctl_decode()  : maps a controller state onto its datapath enables
//
// No ports; imported by seq_mult_ctrl.
//-----------------------------------------------------------------------------
package seq_mult_pkg;

  // Default multiplier width; nine iterations reproduce the cycle count of
  // the old 11-entry control ROM (1 load + 9 shift-add + 1 done).
  localparam int MY_WIDTH_DFLT = 9;

  // All four encodings are used, so there is no spare code to decode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Control vector layout. The names follow the datapath enable names.
  localparam int CTL_W         = 7;
  localparam int CTL_LOAD_MX   = 0;
  localparam int CTL_LOAD_MY   = 1;
  localparam int CTL_SHIFT_MY  = 2;
  localparam int CTL_CLEAR_ACC = 3;
  localparam int CTL_LOAD_ACC  = 4;
  localparam int CTL_SHIFT_IN  = 5;
  localparam int CTL_LOAD_RES  = 6;

  // Datapath enables that are active while the controller sits in 'st'.
  function automatic logic [CTL_W-1:0] ctl_decode(input state_t st);
    logic [CTL_W-1:0] ctl;
    ctl = '0;
    case (st)
      ST_LOAD: begin
        ctl[CTL_LOAD_MX]   = 1'b1;
        ctl[CTL_LOAD_MY]   = 1'b1;
        ctl[CTL_CLEAR_ACC] = 1'b1;
      end
      ST_ITER: begin
        ctl[CTL_SHIFT_MY]  = 1'b1;
        ctl[CTL_LOAD_ACC]  = 1'b1;
        ctl[CTL_SHIFT_IN]  = 1'b1;
      end
      ST_DONE: begin
        ctl[CTL_LOAD_RES]  = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
    return ctl;
  endfunction

  // BUSY covers the cycles in which the datapath is being driven.
  function automatic logic busy_decode(input state_t st);
    return (st == ST_LOAD) || (st == ST_ITER);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
//-----------------------------------------------------------------------------
// seq_mult_ctrl
//
// Counter-driven FSM that sequences the shift-add multiplier datapath
// (MX multiplicand register, MY shifting multiplier register, accumulator).
// One operation is: LOAD (1 cycle), ITER (MY_WIDTH cycles), DONE (1 cycle).
//
// Parameters:
//   MY_WIDTH  multiplier width = number of shift-add iterations (2..64)
//   CNT_W     iteration counter width, derived from MY_WIDTH
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   request a multiplication (sampled in IDLE, or DONE when
//                   back-to-back operation is compiled in)
//   ABORT      in   synchronous cancel while in LOAD or ITER
//   LOAD_MX    out  load multiplicand register
//   LOAD_MY    out  load multiplier register
//   SHIFT_MY   out  shift multiplier register one bit
//   CLEAR_ACC  out  clear accumulator
//   LOAD_ACC   out  accumulator add/load enable
//   SHIFT_IN   out  accumulator shift-in enable
//   LOAD_RES   out  latch product into the result register
//   BUSY       out  operation in progress (LOAD or ITER)
//   DONE       out  one-cycle completion pulse
//   ITER_CNT   out  current iteration index, 0 outside ITER
//
// Build option:
//   SEQ_MULT_B2B_EN  when defined, START seen in DONE goes straight to LOAD
//                    so consecutive products follow with no idle gap.
//-----------------------------------------------------------------------------
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter  int MY_WIDTH = MY_WIDTH_DFLT,
  localparam int CNT_W    = $clog2(MY_WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic             LOAD_MX,
  output logic             LOAD_MY,
  output logic             SHIFT_MY,
  output logic             CLEAR_ACC,
  output logic             LOAD_ACC,
  output logic             SHIFT_IN,
  output logic             LOAD_RES,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ITER_CNT
);

  // Index of the final shift-add iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MY_WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTL_W-1:0]   ctl_q, ctl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and counter logic. The counter only runs in ITER and is
  // forced back to zero everywhere else, which is what keeps ITER_CNT at 0
  // outside ITER without any extra output gating.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ABORT ? ST_IDLE : ST_ITER;
      end
      ST_ITER: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
`ifdef SEQ_MULT_B2B_EN
        state_d = START ? ST_LOAD : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so every control line comes straight from a flop and is glitch-free.
  always_comb begin
    ctl_d  = ctl_decode(state_d);
    busy_d = busy_decode(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and output registers. Reset clears everything at once,
  // so an operation in flight is dropped without a DONE or LOAD_RES pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LOAD_MX   = ctl_q[CTL_LOAD_MX];
  assign LOAD_MY   = ctl_q[CTL_LOAD_MY];
  assign SHIFT_MY  = ctl_q[CTL_SHIFT_MY];
  assign CLEAR_ACC = ctl_q[CTL_CLEAR_ACC];
  assign LOAD_ACC  = ctl_q[CTL_LOAD_ACC];
  assign SHIFT_IN  = ctl_q[CTL_SHIFT_IN];
  assign LOAD_RES  = ctl_q[CTL_LOAD_RES];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ITER_CNT  = cnt_q;

endmodule
